alu_arbiter: RTL

Shares a single combinational ALU (ADD, SUB, INV, RED_OR) among `NUM_REQ` requesters. Round-robin arbitration with per-requester valid/ready handshake; the block registers the winner's operands, drives the ALU for one cycle, and captures the result. It returns the result on a single response channel tagged with the requester index. It sits between client blocks and the ALU instance; clients never drive the ALU directly.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_arbiter_rr_arbiter.sv | 31 +++
 rtl/alu_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and arbiter FSM state type.
package alu_pkg;

  localparam int ALU_OPCODE_W = 2;

  typedef enum logic [ALU_OPCODE_W-1:0] {
    ADD    = 2'b00,
    SUB    = 2'b01,
    INV    = 2'b10,
    RED_OR = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (en && !found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one combinational ALU among NUM_REQ clients
// and returns each result on a single tagged response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 2,
  parameter int CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [2*NUM_REQ-1:0]          req_opcode,
  input  logic [WIDTH*NUM_REQ-1:0]      req_a,
  input  logic [WIDTH*NUM_REQ-1:0]      req_b,
  output logic [ALU_OPCODE_W-1:0]       alu_opcode,
  output logic [WIDTH-1:0]              alu_a,
  output logic [WIDTH-1:0]              alu_b,
  input  logic [WIDTH-1:0]              alu_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]              rsp_result,
  output logic [CNT_W-1:0]              op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e            state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg;
  logic [IDX_W-1:0]  id_reg;
  opcode_e           op_reg;
  logic [WIDTH-1:0]  a_reg, b_reg, result_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;
  logic               arb_en;

  logic [1:0]       opcode_arr [NUM_REQ];
  logic [WIDTH-1:0] a_arr      [NUM_REQ];
  logic [WIDTH-1:0] b_arr      [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign opcode_arr[gi] = req_opcode[2*gi +: 2];
    assign a_arr[gi]      = req_a[WIDTH*gi +: WIDTH];
    assign b_arr[gi]      = req_b[WIDTH*gi +: WIDTH];
  end

  // Grants only in IDLE and never while reset is held, so req_ready is forced low in reset.
  assign arb_en = rst_n && (state_reg == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|grant) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      id_reg     <= '0;
      op_reg     <= ADD;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg  <= opcode_e'(opcode_arr[grant_idx]);
        a_reg   <= a_arr[grant_idx];
        b_reg   <= b_arr[grant_idx];
        id_reg  <= grant_idx;
        ptr_reg <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      if (state_reg == EXEC) result_reg <= alu_result;
      if (state_reg == RESP && rsp_ready) count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign req_ready  = grant;
  assign alu_opcode = op_reg;
  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign rsp_id     = id_reg;
  assign rsp_result = result_reg;
  assign op_count   = count_reg;

endmodule
